// File: rtl/cache_byte_writer.sv
// cache_byte_writer: 8-set direct-mapped write-back cache that accepts CPU
// byte writes and merges them into 32-bit blocks. A write miss walks
// WRITEBACK (dirty victims only) -> FETCH -> ALLOCATE, then merges as a hit.
// Optional feature: define CACHE_WB_COUNT_EN to get a 16-bit write-back counter
// on wb_count. Without it, wb_count is tied to zero.
module cache_byte_writer (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        write,
  input  logic [7:0]  address,
  input  logic [7:0]  writedata,
  output logic        busywait,
  output logic        mem_read,
  output logic        mem_write,
  output logic [5:0]  mem_address,
  output logic [31:0] mem_writedata,
  input  logic [31:0] mem_readdata,
  input  logic        mem_busywait,
  input  logic [2:0]  rd_index,
  output logic [31:0] rd_block,
  output logic [15:0] wb_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2,
    ALLOCATE  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [7:0][31:0]  data_q,  data_d;
  logic [7:0][2:0]   tag_q,   tag_d;
  logic [7:0]        valid_q, valid_d;
  logic [7:0]        dirty_q, dirty_d;

  logic [2:0] tag_in;
  logic [2:0] idx;
  logic [1:0] off;
  logic       hit;

  assign tag_in = address[7:5];
  assign idx    = address[4:2];
  assign off    = address[1:0];
  assign hit    = valid_q[idx] && (tag_q[idx] == tag_in);

  // Downstream block read; always shows the registered (pre-edge) contents.
  assign rd_block = data_q[rd_index];

  // Next-state, array updates and memory-side outputs for the current state.
  always_comb begin
    state_d       = state_q;
    data_d        = data_q;
    tag_d         = tag_q;
    valid_d       = valid_q;
    dirty_d       = dirty_q;
    busywait      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    mem_address   = '0;
    mem_writedata = '0;
    case (state_q)
      IDLE: begin
        if (write) begin
          if (hit) begin
            data_d[idx][{off, 3'b000} +: 8] = writedata;
            dirty_d[idx]                    = 1'b1;
          end else begin
            busywait = 1'b1;
            state_d  = (valid_q[idx] && dirty_q[idx]) ? WRITEBACK : FETCH;
          end
        end
      end
      WRITEBACK: begin
        busywait      = 1'b1;
        mem_write     = 1'b1;
        mem_address   = {tag_q[idx], idx};
        mem_writedata = data_q[idx];
        if (!mem_busywait) state_d = FETCH;
      end
      FETCH: begin
        busywait    = 1'b1;
        mem_read    = 1'b1;
        mem_address = {tag_in, idx};
        if (!mem_busywait) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        busywait     = 1'b1;
        data_d[idx]  = mem_readdata;
        tag_d[idx]   = tag_in;
        valid_d[idx] = 1'b1;
        dirty_d[idx] = 1'b0;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and cache array registers with synchronous reset.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      data_q  <= '0;
      tag_q   <= '0;
      valid_q <= '0;
      dirty_q <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      tag_q   <= tag_d;
      valid_q <= valid_d;
      dirty_q <= dirty_d;
    end
  end

`ifdef CACHE_WB_COUNT_EN
  logic [15:0] wb_count_q, wb_count_d;
  logic        wb_done;

  assign wb_done = (state_q == WRITEBACK) && !mem_busywait;

  // Count completed write-backs, wrapping modulo 2^16.
  always_comb begin
    wb_count_d = wb_count_q;
    if (wb_done) wb_count_d = wb_count_q + 16'd1;
  end

  // Write-back counter register.
  always_ff @(posedge CLK) begin
    if (RESET) wb_count_q <= '0;
    else       wb_count_q <= wb_count_d;
  end

  assign wb_count = wb_count_q;
`else
  assign wb_count = '0;
`endif

endmodule

// File: tb/tb_cache_byte_writer.sv
// tb_cache_byte_writer: directed vector table plus hand sequences for
// stalls, dropped writes and reset during write-back.
module tb_cache_byte_writer;

`ifdef CACHE_WB_COUNT_EN
  localparam int WBEN = 1;
`else
  localparam int WBEN = 0;
`endif

  logic        CLK = 1'b0;
  logic        RESET;
  logic        write;
  logic [7:0]  address;
  logic [7:0]  writedata;
  logic        busywait;
  logic        mem_read;
  logic        mem_write;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata;
  logic        mem_busywait;
  logic [2:0]  rd_index;
  logic [31:0] rd_block;
  logic [15:0] wb_count;

  int checks = 0;
  int errors = 0;

  cache_byte_writer dut (
    .CLK           (CLK),
    .RESET         (RESET),
    .write         (write),
    .address       (address),
    .writedata     (writedata),
    .busywait      (busywait),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .mem_address   (mem_address),
    .mem_writedata (mem_writedata),
    .mem_readdata  (mem_readdata),
    .mem_busywait  (mem_busywait),
    .rd_index      (rd_index),
    .rd_block      (rd_block),
    .wb_count      (wb_count)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [7:0]  wd;
    logic        mbw;
    logic [31:0] mrd;
    logic [2:0]  ri;
    logic        e_bw;
    logic        e_mr;
    logic        e_mw;
    logic [5:0]  e_ma;
    logic [31:0] e_mwd;
    logic [31:0] e_rb;
    logic [15:0] e_wb;
  } vec_t;

  vec_t vt [15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic wr, input logic [7:0] addr, input logic [7:0] wd,
                       input logic mbw, input logic [31:0] mrd, input logic [2:0] ri);
    write        = wr;
    address      = addr;
    writedata    = wd;
    mem_busywait = mbw;
    mem_readdata = mrd;
    rd_index     = ri;
  endtask

  task automatic adv();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    //          wr   addr   wd     mbw  mrd           ri  | bw   mr   mw   ma     mwd           rb            wb
    vt[0]  = '{1'b0, 8'h00, 8'h00, 1'b1, 32'h0,        3'd0, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0,        32'h0,        16'd0};
    vt[1]  = '{1'b1, 8'h05, 8'hAB, 1'b1, 32'h0,        3'd1, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0,        32'h0,        16'd0};
    vt[2]  = '{1'b1, 8'h05, 8'hAB, 1'b1, 32'h0,        3'd1, 1'b1, 1'b1, 1'b0, 6'h01, 32'h0,        32'h0,        16'd0};
    vt[3]  = '{1'b1, 8'h05, 8'hAB, 1'b0, 32'h11223344, 3'd1, 1'b1, 1'b1, 1'b0, 6'h01, 32'h0,        32'h0,        16'd0};
    vt[4]  = '{1'b1, 8'h05, 8'hAB, 1'b0, 32'h11223344, 3'd1, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0,        32'h0,        16'd0};
    vt[5]  = '{1'b1, 8'h05, 8'hAB, 1'b1, 32'h0,        3'd1, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0,        32'h11223344, 16'd0};
    vt[6]  = '{1'b1, 8'h07, 8'hCD, 1'b1, 32'h0,        3'd1, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0,        32'h1122AB44, 16'd0};
    vt[7]  = '{1'b0, 8'h07, 8'hCD, 1'b1, 32'h0,        3'd1, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0,        32'hCD22AB44, 16'd0};
    vt[8]  = '{1'b1, 8'h25, 8'h5A, 1'b1, 32'h0,        3'd1, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0,        32'hCD22AB44, 16'd0};
    vt[9]  = '{1'b1, 8'h25, 8'h5A, 1'b1, 32'h0,        3'd1, 1'b1, 1'b0, 1'b1, 6'h01, 32'hCD22AB44, 32'hCD22AB44, 16'd0};
    vt[10] = '{1'b1, 8'h25, 8'h5A, 1'b0, 32'h0,        3'd1, 1'b1, 1'b0, 1'b1, 6'h01, 32'hCD22AB44, 32'hCD22AB44, 16'd0};
    vt[11] = '{1'b1, 8'h25, 8'h5A, 1'b0, 32'hA0B0C0D0, 3'd1, 1'b1, 1'b1, 1'b0, 6'h09, 32'h0,        32'hCD22AB44, 16'd1};
    vt[12] = '{1'b1, 8'h25, 8'h5A, 1'b0, 32'hA0B0C0D0, 3'd1, 1'b1, 1'b0, 1'b0, 6'h00, 32'h0,        32'hCD22AB44, 16'd1};
    vt[13] = '{1'b1, 8'h25, 8'h5A, 1'b1, 32'h0,        3'd1, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0,        32'hA0B0C0D0, 16'd1};
    vt[14] = '{1'b0, 8'h25, 8'h5A, 1'b1, 32'h0,        3'd1, 1'b0, 1'b0, 1'b0, 6'h00, 32'h0,        32'hA0B05AD0, 16'd1};

    RESET = 1'b1;
    drive(1'b0, 8'h00, 8'h00, 1'b1, 32'h0, 3'd0);
    repeat (2) @(posedge CLK);
    #1;
    RESET = 1'b0;

    // Main vector table: one row per clock cycle.
    for (int i = 0; i < 15; i++) begin
      drive(vt[i].wr, vt[i].addr, vt[i].wd, vt[i].mbw, vt[i].mrd, vt[i].ri);
      @(negedge CLK);
      chk($sformatf("v%0d busywait", i),      {31'b0, busywait},      {31'b0, vt[i].e_bw});
      chk($sformatf("v%0d mem_read", i),      {31'b0, mem_read},      {31'b0, vt[i].e_mr});
      chk($sformatf("v%0d mem_write", i),     {31'b0, mem_write},     {31'b0, vt[i].e_mw});
      chk($sformatf("v%0d mem_address", i),   {26'b0, mem_address},   {26'b0, vt[i].e_ma});
      chk($sformatf("v%0d mem_writedata", i), mem_writedata,          vt[i].e_mwd);
      chk($sformatf("v%0d rd_block", i),      rd_block,               vt[i].e_rb);
      chk($sformatf("v%0d wb_count", i),      {16'b0, wb_count},      {16'b0, vt[i].e_wb * 16'(WBEN)});
      adv();
    end

    // Long memory stall in FETCH: set 0 invalid, tag 2, offset 2.
    drive(1'b1, 8'h42, 8'h77, 1'b1, 32'h0, 3'd0);
    @(negedge CLK);
    chk("stall idle busywait", {31'b0, busywait}, 32'd1);
    chk("stall idle mem_read", {31'b0, mem_read}, 32'd0);
    adv();
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      chk($sformatf("stall%0d busywait", i),  {31'b0, busywait},    32'd1);
      chk($sformatf("stall%0d mem_read", i),  {31'b0, mem_read},    32'd1);
      chk($sformatf("stall%0d mem_write", i), {31'b0, mem_write},   32'd0);
      chk($sformatf("stall%0d mem_addr", i),  {26'b0, mem_address}, 32'h10);
      adv();
    end
    drive(1'b1, 8'h42, 8'h77, 1'b0, 32'h01020304, 3'd0);
    @(negedge CLK);
    chk("stall release mem_read", {31'b0, mem_read}, 32'd1);
    adv();
    @(negedge CLK);
    chk("stall alloc busywait", {31'b0, busywait}, 32'd1);
    chk("stall alloc mem_read", {31'b0, mem_read}, 32'd0);
    adv();
    @(negedge CLK);
    chk("stall hit busywait", {31'b0, busywait}, 32'd0);
    chk("stall hit pre-merge", rd_block, 32'h01020304);
    adv();
    drive(1'b0, 8'h42, 8'h77, 1'b1, 32'h0, 3'd0);
    @(negedge CLK);
    chk("stall merged block", rd_block, 32'h01770304);
    adv();

    // Write dropped during FETCH: set 3 allocated clean, no merge.
    drive(1'b1, 8'h8C, 8'h99, 1'b1, 32'h0, 3'd3);
    @(negedge CLK);
    chk("drop idle busywait", {31'b0, busywait}, 32'd1);
    adv();
    write = 1'b0;
    @(negedge CLK);
    chk("drop fetch mem_read", {31'b0, mem_read},    32'd1);
    chk("drop fetch mem_addr", {26'b0, mem_address}, 32'h23);
    chk("drop fetch busywait", {31'b0, busywait},    32'd1);
    adv();
    drive(1'b0, 8'h8C, 8'h99, 1'b0, 32'hDEADBEEF, 3'd3);
    @(negedge CLK);
    chk("drop fetch2 mem_read", {31'b0, mem_read}, 32'd1);
    adv();
    @(negedge CLK);
    chk("drop alloc busywait", {31'b0, busywait}, 32'd1);
    adv();
    drive(1'b0, 8'h8C, 8'h99, 1'b1, 32'h0, 3'd3);
    @(negedge CLK);
    chk("drop idle busywait2", {31'b0, busywait}, 32'd0);
    chk("drop unmerged block", rd_block, 32'hDEADBEEF);
    adv();
    // Clean victim: a conflicting write must go straight to FETCH.
    drive(1'b1, 8'hAC, 8'h11, 1'b1, 32'h0, 3'd3);
    @(negedge CLK);
    chk("clean victim busywait", {31'b0, busywait}, 32'd1);
    adv();
    @(negedge CLK);
    chk("clean victim mem_read",  {31'b0, mem_read},    32'd1);
    chk("clean victim mem_write", {31'b0, mem_write},   32'd0);
    chk("clean victim mem_addr",  {26'b0, mem_address}, 32'h2B);
    drive(1'b0, 8'hAC, 8'h11, 1'b0, 32'h0, 3'd3);
    adv();
    adv();

    // Reset asserted during WRITEBACK of dirty set 0.
    drive(1'b1, 8'h60, 8'h00, 1'b1, 32'h0, 3'd0);
    @(negedge CLK);
    chk("rst idle busywait", {31'b0, busywait}, 32'd1);
    adv();
    @(negedge CLK);
    chk("rst wb mem_write", {31'b0, mem_write},   32'd1);
    chk("rst wb mem_addr",  {26'b0, mem_address}, 32'h10);
    chk("rst wb mem_wdata", mem_writedata,        32'h01770304);
    RESET = 1'b1;
    adv();
    RESET = 1'b0;
    write = 1'b0;
    @(negedge CLK);
    chk("rst after mem_write", {31'b0, mem_write},   32'd0);
    chk("rst after mem_read",  {31'b0, mem_read},    32'd0);
    chk("rst after busywait",  {31'b0, busywait},    32'd0);
    chk("rst after mem_addr",  {26'b0, mem_address}, 32'h0);
    chk("rst after wb_count",  {16'b0, wb_count},    32'd0);
    for (int i = 0; i < 8; i++) begin
      rd_index = 3'(i);
      #1;
      chk($sformatf("rst rd_block[%0d]", i), rd_block, 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cache_byte_writer.md
CACHE_BYTE_WRITER -- requirements
Module: cache_byte_writer

Interface
REQ-001 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port RESET, input, 1 bit: reset, synchronous and active-high.
REQ-003 The block SHALL have port write, input, 1 bit: CPU byte-write request, held high until busywait is low.
REQ-004 The block SHALL have port address, input, 8 bits: tag = bits 7:5, index = bits 4:2, offset = bits 1:0.
REQ-005 The block SHALL have port writedata, input, 8 bits: the byte to store.
REQ-006 The block SHALL have port busywait, output, 1 bit: CPU stall.
REQ-007 The block SHALL have port mem_read and port mem_write, each an output of 1 bit: memory request strobes.
REQ-008 The block SHALL have port mem_address, output, 6 bits: the memory block address {tag,index}.
REQ-009 The block SHALL have port mem_writedata, output, 32 bits: the write-back block.
REQ-010 The block SHALL have port mem_readdata, input, 32 bits, and port mem_busywait, input, 1 bit: the memory response.
REQ-011 The block SHALL have port rd_index, input, 3 bits, and port rd_block, output, 32 bits: a combinational block read for the downstream byte selector.
REQ-012 The block SHALL have port wb_count, output, 16 bits: the write-back counter (see Configuration).

Function
REQ-013 The block SHALL store 8 sets; each set SHALL hold data[31:0], tag[2:0], valid and dirty.
REQ-014 Hit SHALL be defined as valid[index] && tag[index]==address[7:5], evaluated combinationally.
REQ-015 States SHALL be IDLE, WRITEBACK, FETCH and ALLOCATE, in a 2-bit state register.
REQ-016 In IDLE with write and hit: busywait=0; at the next edge, byte offset k (0..3) SHALL replace data bits [8k+7:8k], dirty SHALL be set, and all other bytes SHALL be unchanged.
REQ-017 In IDLE with write, miss and a dirty victim: busywait=1 combinationally; at the next edge the state SHALL go to WRITEBACK.
REQ-018 In IDLE with write, miss and a clean or invalid victim: busywait=1; at the next edge the state SHALL go to FETCH.
REQ-019 In WRITEBACK: mem_write=1, mem_address={victim tag,index}, mem_writedata=victim data; the state SHALL advance to FETCH at the first edge where mem_busywait=0.
REQ-020 In FETCH: mem_read=1, mem_address={address tag,index}; the state SHALL advance to ALLOCATE at the first edge where mem_busywait=0.
REQ-021 In ALLOCATE: data SHALL be loaded from mem_readdata, tag and valid=1 written, dirty=0, busywait=1, and the state SHALL return to IDLE. The write then hits and merges per REQ-016.
REQ-022 Outside WRITEBACK and FETCH, mem_read and mem_write SHALL be 0, and the two SHALL never be high together.
REQ-023 Write-miss latency SHALL be 1 + N_wb + N_fetch + 1 cycles of busywait, where N is the number of memory cycles until mem_busywait=0.
REQ-024 If write drops while the block is in a non-IDLE state, the in-flight memory transaction SHALL complete and the block SHALL return to IDLE with no merge.
REQ-025 rd_block SHALL equal data[rd_index] combinationally. If rd_index equals the index being merged in the same cycle, rd_block SHALL show the pre-edge value.
REQ-026 If write is low in IDLE, nothing SHALL change.

Reset
REQ-027 When RESET=1 at an edge: state=IDLE, all valid=0, all dirty=0, wb_count=0.
REQ-028 While in IDLE after reset, busywait=0, mem_read=0, mem_write=0, mem_address=0 and mem_writedata=0.
REQ-029 Data and tag arrays SHALL reset to 0.
REQ-030 A RESET asserted mid-WRITEBACK or mid-FETCH SHALL abort immediately; the memory strobes SHALL be low in the following cycle.

Configuration
REQ-031 With macro CACHE_WB_COUNT_EN defined, wb_count SHALL increment by 1 (modulo 2^16) on each WRITEBACK-to-FETCH transition.
REQ-032 Without CACHE_WB_COUNT_EN, wb_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-033 Reset, then write address 0x05, data 0xAB -> miss; FETCH with mem_address 0x01; mem_readdata 0x11223344 -> set 1 becomes 0x1122AB44, dirty=1.
REQ-034 After REQ-033, write address 0x07, data 0xCD -> no stall; rd_index=1 shows 0xCD22AB44 on the next cycle.
REQ-035 Write address 0x25 (tag 1, set 1 dirty) -> WRITEBACK with mem_address 0x01 and mem_writedata 0xCD22AB44, then FETCH 0x09; wb_count=1 when CACHE_WB_COUNT_EN is defined, else 0.
REQ-036 mem_busywait held high for 5 cycles in FETCH -> busywait stays 1 throughout and mem_read stays 1; mem_write=0 throughout.
REQ-037 RESET pulsed during WRITEBACK -> next cycle state IDLE, mem_write=0, and rd_block=0 for every index.
REQ-038 write deasserted during FETCH -> after mem_busywait falls the block is allocated clean (dirty=0) and no byte is merged.
